// File: rtl/sram_1rw1r_arbiter.sv
// rtl/sram_1rw1r_arbiter.sv - round-robin RW-port arbiter and read-port sequencer for a 1RW1R SRAM macro
module sram_1rw1r_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [NUM_WMASKS-1:0] m0_wmask,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [NUM_WMASKS-1:0] m1_wmask,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  input  logic                  r_req,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_ack,
  output logic [DATA_WIDTH-1:0] r_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic [15:0]           hazard_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT, ST_ACK} state_t;

  state_t r_p0_state, w_p0_next;
  state_t r_p1_state, w_p1_next;
  logic   r_last_m1;
  logic   r_gnt_m1;
  logic   r_p0_rd;

  logic                  w_p0_go;
  logic                  w_pick_m1;
  logic                  w_we;
  logic [NUM_WMASKS-1:0] w_wmask;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_hazard;
  logic                  w_p1_go;

  // Round robin: on contention the master that did not win last time is granted.
  assign w_p0_go   = (r_p0_state == ST_IDLE) && (m0_req || m1_req);
  assign w_pick_m1 = m1_req && (!m0_req || !r_last_m1);
  assign w_we      = w_pick_m1 ? m1_we    : m0_we;
  assign w_wmask   = w_pick_m1 ? m1_wmask : m0_wmask;
  assign w_addr    = w_pick_m1 ? m1_addr  : m0_addr;
  assign w_wdata   = w_pick_m1 ? m1_wdata : m0_wdata;

  // A read launched alongside a same-address write would see stale data; hold it one cycle.
  assign w_hazard = (r_p1_state == ST_IDLE) && r_req && w_p0_go && w_we && (w_addr == r_addr);
  assign w_p1_go  = (r_p1_state == ST_IDLE) && r_req && !w_hazard;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_p0_state <= ST_IDLE;
      r_p1_state <= ST_IDLE;
    end else begin
      r_p0_state <= w_p0_next;
      r_p1_state <= w_p1_next;
    end
  end

  always_comb begin
    w_p0_next = r_p0_state;
    unique case (r_p0_state)
      ST_IDLE: if (w_p0_go) w_p0_next = ST_CMD;
      ST_CMD:  w_p0_next = ST_WAIT;
      ST_WAIT: w_p0_next = ST_ACK;
      ST_ACK:  w_p0_next = ST_IDLE;
      default: w_p0_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_p1_next = r_p1_state;
    unique case (r_p1_state)
      ST_IDLE: if (w_p1_go) w_p1_next = ST_CMD;
      ST_CMD:  w_p1_next = ST_WAIT;
      ST_WAIT: w_p1_next = ST_ACK;
      ST_ACK:  w_p1_next = ST_IDLE;
      default: w_p1_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      r_last_m1   <= 1'b1;
      r_gnt_m1    <= 1'b0;
      r_p0_rd     <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      unique case (r_p0_state)
        ST_IDLE: begin
          if (w_p0_go) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= ~w_we;
            sram_wmask0 <= w_wmask;
            sram_addr0  <= w_addr;
            sram_din0   <= w_wdata;
            r_gnt_m1    <= w_pick_m1;
            r_last_m1   <= w_pick_m1;
            r_p0_rd     <= ~w_we;
          end
        end
        ST_CMD: begin
          sram_csb0 <= 1'b1;
          sram_web0 <= 1'b1;
        end
        ST_WAIT: begin
          if (r_gnt_m1) begin
            m1_ack <= 1'b1;
            if (r_p0_rd) m1_rdata <= sram_dout0;
          end else begin
            m0_ack <= 1'b1;
            if (r_p0_rd) m0_rdata <= sram_dout0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sram_csb1  <= 1'b1;
      sram_addr1 <= '0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      hazard_cnt <= '0;
    end else begin
      r_ack <= 1'b0;
      if (w_hazard && (hazard_cnt != 16'hFFFF)) hazard_cnt <= hazard_cnt + 16'd1;
      unique case (r_p1_state)
        ST_IDLE: begin
          if (w_p1_go) begin
            sram_csb1  <= 1'b0;
            sram_addr1 <= r_addr;
          end
        end
        ST_CMD:  sram_csb1 <= 1'b1;
        ST_WAIT: begin
          r_ack   <= 1'b1;
          r_rdata <= sram_dout1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// tb/tb_sram_1rw1r_arbiter.sv - scoreboard bench for sram_1rw1r_arbiter with a behavioural 1RW1R macro
module tb_sram_1rw1r_arbiter;

  logic        clk = 1'b0;
  logic        resetb;
  logic        m0_req, m0_we, m1_req, m1_we, r_req;
  logic [3:0]  m0_wmask, m1_wmask;
  logic [7:0]  m0_addr, m1_addr, r_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, r_ack;
  logic [31:0] m0_rdata, m1_rdata, r_rdata;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;
  logic [15:0] hazard_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] qr[$];
  int          order_q[$];

  sram_1rw1r_arbiter dut (
    .clk(clk), .resetb(resetb),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .r_req(r_req), .r_addr(r_addr), .r_ack(r_ack), .r_rdata(r_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
    .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  // Macro model: controls sampled at posedge, array accessed at the following negedge.
  // Port 1 reads the pre-write contents when both ports hit the same negedge.
  logic [31:0] mem [256];
  logic        mem_init = 1'b0;
  logic        p0_en = 1'b0, p0_we = 1'b0, p1_en = 1'b0;
  logic [3:0]  p0_mask;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_din;

  always @(posedge clk) begin
    p0_en   <= !sram_csb0;
    p0_we   <= !sram_web0;
    p0_mask <= sram_wmask0;
    p0_addr <= sram_addr0;
    p0_din  <= sram_din0;
    p1_en   <= !sram_csb1;
    p1_addr <= sram_addr1;
  end

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h30] <= 32'hCAFEF00D;
      mem[8'h21] <= 32'h12345678;
      mem_init   <= 1'b1;
    end else begin
      if (p1_en) sram_dout1 <= mem[p1_addr];
      if (p0_en) begin
        if (p0_we) begin
          for (int b = 0; b < 4; b++)
            if (p0_mask[b]) mem[p0_addr][8*b +: 8] <= p0_din[8*b +: 8];
        end else begin
          sram_dout0 <= mem[p0_addr];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an ack, expected none", name);
  endtask

  task automatic monitor();
    logic p0, p1, pr;
    int   id;
    p0 = 1'b0; p1 = 1'b0; pr = 1'b0;
    forever begin
      @(negedge clk);
      if (resetb) begin
        if (m0_ack) begin
          check("m0_ack single cycle", {31'b0, p0}, 32'd0);
          if (q0.size() == 0 || order_q.size() == 0) unexpected("m0 unexpected ack");
          else begin
            check("m0_rdata", m0_rdata, q0.pop_front());
            id = order_q.pop_front();
            check("grant order (m0 acked)", 32'(id), 32'd0);
          end
        end
        if (m1_ack) begin
          check("m1_ack single cycle", {31'b0, p1}, 32'd0);
          if (q1.size() == 0 || order_q.size() == 0) unexpected("m1 unexpected ack");
          else begin
            check("m1_rdata", m1_rdata, q1.pop_front());
            id = order_q.pop_front();
            check("grant order (m1 acked)", 32'(id), 32'd1);
          end
        end
        if (r_ack) begin
          check("r_ack single cycle", {31'b0, pr}, 32'd0);
          if (qr.size() == 0) unexpected("r unexpected ack");
          else check("r_rdata", r_rdata, qr.pop_front());
        end
      end
      p0 = m0_ack; p1 = m1_ack; pr = r_ack;
    end
  endtask

  // Starts with the port-0 FSM idle; returns with it idle again.
  task automatic m_access(input int id, input logic we, input logic [3:0] mask,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata);
    int cyc;
    if (id == 0) begin
      q0.push_back(exp_rdata);
      m0_we = we; m0_wmask = mask; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      q1.push_back(exp_rdata);
      m1_we = we; m1_wmask = mask; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
    order_q.push_back(id);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!((id == 0) ? m0_ack : m1_ack) && cyc < 20);
    check((id == 0) ? "m0 ack latency" : "m1 ack latency", 32'(cyc), 32'd3);
    if (id == 0) m0_req = 1'b0; else m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic r_access(input logic [7:0] addr, input logic [31:0] exp_rdata, input int exp_lat);
    int cyc;
    qr.push_back(exp_rdata);
    r_addr = addr;
    r_req  = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!r_ack && cyc < 20);
    check("r ack latency", 32'(cyc), 32'(exp_lat));
    r_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
  endtask

  initial begin
    int acks, csb_low;
    resetb = 1'b0;
    m0_req = 0; m0_we = 0; m0_wmask = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_wmask = 0; m1_addr = 0; m1_wdata = 0;
    r_req = 0; r_addr = 0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("reset sram_csb0", {31'b0, sram_csb0}, 32'd1);
    check("reset sram_web0", {31'b0, sram_web0}, 32'd1);
    check("reset sram_csb1", {31'b0, sram_csb1}, 32'd1);
    check("reset sram_addr0", {24'b0, sram_addr0}, 32'd0);
    check("reset acks", {29'b0, m0_ack, m1_ack, r_ack}, 32'd0);
    check("reset hazard_cnt", {16'b0, hazard_cnt}, 32'd0);
    resetb = 1'b1;
    @(posedge clk); #1;

    // Full-word write/read, then partial-mask merge from the other master.
    m_access(0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 32'h0);
    m_access(0, 1'b0, 4'h0, 8'h10, 32'h0, 32'hDEADBEEF);
    m_access(1, 1'b1, 4'b0101, 8'h10, 32'h11223344, 32'h0);
    m_access(1, 1'b0, 4'h0, 8'h10, 32'h0, 32'hDE22BE44);

    // Both masters request continuously after reset.
    do_reset();
    check("m0_rdata cleared by reset", m0_rdata, 32'h0);
    q0.push_back(32'hDE22BE44); q1.push_back(32'hCAFEF00D);
    q0.push_back(32'hDE22BE44); q1.push_back(32'hCAFEF00D);
    order_q.push_back(0); order_q.push_back(1); order_q.push_back(0); order_q.push_back(1);
    m0_we = 1'b0; m0_addr = 8'h10; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = 8'h30; m1_req = 1'b1;
    acks = 0; csb_low = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      @(posedge clk); #1;
      if (!sram_csb0) csb_low++;
      if (m0_ack || m1_ack) acks++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("round-robin ack count", 32'(acks), 32'd4);
    check("sram_csb0 low cycles", 32'(csb_low), 32'd4);
    repeat (2) @(posedge clk);
    #1;

    // Same-address write and read in one idle cycle: read deferred, sees new data.
    fork
      m_access(1, 1'b1, 4'hF, 8'h20, 32'h0BADF00D, 32'hCAFEF00D);
      r_access(8'h20, 32'h0BADF00D, 4);
    join
    check("hazard_cnt after collision", {16'b0, hazard_cnt}, 32'd1);
    fork
      m_access(1, 1'b1, 4'hF, 8'h20, 32'h55AA55AA, 32'hCAFEF00D);
      r_access(8'h21, 32'h12345678, 3);
    join
    check("hazard_cnt different address", {16'b0, hazard_cnt}, 32'd1);

    // Reset while port 0 is in WAIT and port 1 is in CMD.
    m0_we = 1'b0; m0_addr = 8'h10; m0_req = 1'b1;
    @(posedge clk); #1;
    r_addr = 8'h21; r_req = 1'b1;
    @(posedge clk); #1;
    check("sram_csb1 low before reset", {31'b0, sram_csb1}, 32'd0);
    resetb = 1'b0;
    #1;
    check("mid-op reset sram_csb0", {31'b0, sram_csb0}, 32'd1);
    check("mid-op reset sram_csb1", {31'b0, sram_csb1}, 32'd1);
    check("mid-op reset acks", {29'b0, m0_ack, m1_ack, r_ack}, 32'd0);
    m0_req = 1'b0; r_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (m0_ack || m1_ack || r_ack) acks++;
    end
    check("no ack after reset release", 32'(acks), 32'd0);
    check("hazard_cnt cleared by reset", {16'b0, hazard_cnt}, 32'd0);
    m_access(0, 1'b0, 4'h0, 8'h10, 32'h0, 32'hDE22BE44);

    repeat (4) @(posedge clk);
    #1;
    check("m0 queue drained", 32'(q0.size()), 32'd0);
    check("m1 queue drained", 32'(q1.size()), 32'd0);
    check("r queue drained", 32'(qr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
